// File: rtl/encode_8_3_seq_if.sv
// Request/present handshake bundle for the 8-to-3 sequential priority encoder.
// The master side drives requests and acknowledges; the slave side presents codes.
interface encode_8_3_seq_if;
   logic       En;
   logic [7:0] I;
   logic       Ack;
   logic [2:0] Y;
   logic       V;
   logic [7:0] Pend;
   logic       Drop;

   modport master (
      output En,
      output I,
      output Ack,
      input  Y,
      input  V,
      input  Pend,
      input  Drop
   );

   modport slave (
      input  En,
      input  I,
      input  Ack,
      output Y,
      output V,
      output Pend,
      output Drop
   );
endinterface

// File: rtl/encode_8_3_seq.sv
// Sequential 8-to-3 priority encoder: accumulates requests in a pending register and
// presents them one at a time with a valid/acknowledge handshake.
module encode_8_3_seq #(
   parameter int unsigned PRIO_HIGH = 1
) (
   input logic              Clk,
   input logic              Rst,
   encode_8_3_seq_if.slave  bus
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   logic       r_state;
   logic [2:0] r_y;
   logic [7:0] r_pend;
   logic       r_drop;

   logic       w_state_d;
   logic [2:0] w_y_d;
   logic [7:0] w_clr;
   logic [7:0] w_cap;
   logic [7:0] w_rem;
   logic [7:0] w_pend_d;
   logic       w_drop_set;

   // Later loop hits overwrite earlier ones, so scan order sets the winner.
   function automatic logic [2:0] f_prio(input logic [7:0] req);
      logic [2:0] idx;
      idx = 3'd0;
      if (PRIO_HIGH != 0) begin
         for (int k = 0; k < 8; k++) begin
            if (req[k]) idx = 3'(k);
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            if (req[k]) idx = 3'(k);
         end
      end
      return idx;
   endfunction

   always_comb begin
      w_clr = 8'h00;
      if (r_state == ST_HOLD && bus.Ack) w_clr = 8'h01 << r_y;
      w_cap      = bus.En ? bus.I : 8'h00;
      w_rem      = r_pend & ~w_clr;
      w_pend_d   = w_rem | w_cap;
      w_drop_set = |(w_cap & w_rem);
   end

   always_comb begin
      w_state_d = r_state;
      w_y_d     = r_y;
      case (r_state)
         ST_IDLE: begin
            if (|r_pend) begin
               w_y_d     = f_prio(r_pend);
               w_state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Same-cycle arrivals are excluded here; they present later via IDLE.
            if (bus.Ack) begin
               if (|w_rem) begin
                  w_y_d = f_prio(w_rem);
               end else begin
                  w_state_d = ST_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= ST_IDLE;
         r_y     <= 3'd0;
         r_pend  <= 8'h00;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_y     <= w_y_d;
         r_pend  <= w_pend_d;
         r_drop  <= r_drop | w_drop_set;
      end
   end

   assign bus.Y    = r_y;
   assign bus.V    = (r_state == ST_HOLD);
   assign bus.Pend = r_pend;
   assign bus.Drop = r_drop;

endmodule

// File: tb/tb_encode_8_3_seq.sv
// Bench for encode_8_3_seq: both priority orders side by side, accepted codes
// checked against per-instance expectation queues.
module tb_encode_8_3_seq;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       ack;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2:0] q_hi[$];
   logic [2:0] q_lo[$];

   encode_8_3_seq_if bus_hi ();
   encode_8_3_seq_if bus_lo ();

   assign bus_hi.En  = en;
   assign bus_hi.I   = req;
   assign bus_hi.Ack = ack;
   assign bus_lo.En  = en;
   assign bus_lo.I   = req;
   assign bus_lo.Ack = ack;

   encode_8_3_seq #(.PRIO_HIGH(1)) dut_hi (.Clk(clk), .Rst(rst), .bus(bus_hi.slave));
   encode_8_3_seq #(.PRIO_HIGH(0)) dut_lo (.Clk(clk), .Rst(rst), .bus(bus_lo.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_both(input logic [2:0] y_hi, input logic [2:0] y_lo);
      q_hi.push_back(y_hi);
      q_lo.push_back(y_lo);
   endtask

   // A handshake completes on the next rising edge whenever V and Ack are both high.
   always @(negedge clk) begin
      if (!rst && bus_hi.V && ack) begin
         if (q_hi.size() == 0) check("hi_unexpected_accept", {5'd0, bus_hi.Y}, 8'hff);
         else check("hi_accept_y", {5'd0, bus_hi.Y}, {5'd0, q_hi.pop_front()});
      end
      if (!rst && bus_lo.V && ack) begin
         if (q_lo.size() == 0) check("lo_unexpected_accept", {5'd0, bus_lo.Y}, 8'hff);
         else check("lo_accept_y", {5'd0, bus_lo.Y}, {5'd0, q_lo.pop_front()});
      end
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      req = 8'h00;
      ack = 1'b0;
      tick();
      tick();
      check("rst_pend", bus_hi.Pend, 8'h00);
      check("rst_v", {7'd0, bus_hi.V}, 8'h00);
      check("rst_y", {5'd0, bus_hi.Y}, 8'h00);
      check("rst_drop", {7'd0, bus_hi.Drop}, 8'h00);

      // Two requests, Ack held: order depends on priority direction.
      rst = 1'b0;
      ack = 1'b1;
      en  = 1'b1;
      req = 8'h24;
      push_both(3'd5, 3'd2);
      push_both(3'd2, 3'd5);
      tick();
      en = 1'b0;
      check("a_first_capture_pend", bus_hi.Pend, 8'h24);
      check("a_v_before_present", {7'd0, bus_hi.V}, 8'h00);
      tick();
      check("a_hi_v", {7'd0, bus_hi.V}, 8'h01);
      check("a_hi_y5", {5'd0, bus_hi.Y}, 8'h05);
      check("a_lo_y2", {5'd0, bus_lo.Y}, 8'h02);
      tick();
      check("a_hi_y2", {5'd0, bus_hi.Y}, 8'h02);
      check("a_lo_y5", {5'd0, bus_lo.Y}, 8'h05);
      check("a_hi_pend_04", bus_hi.Pend, 8'h04);
      tick();
      check("a_hi_v_idle", {7'd0, bus_hi.V}, 8'h00);
      check("a_lo_v_idle", {7'd0, bus_lo.V}, 8'h00);
      check("a_hi_pend_empty", bus_hi.Pend, 8'h00);
      check("a_hi_drop", {7'd0, bus_hi.Drop}, 8'h00);
      tick();
      check("a_ack_idle_ignored", {7'd0, bus_hi.V}, 8'h00);

      // Stall: higher-priority arrival must not disturb the held code.
      ack = 1'b0;
      en  = 1'b1;
      req = 8'h02;
      push_both(3'd1, 3'd1);
      push_both(3'd7, 3'd7);
      tick();
      en = 1'b0;
      tick();
      check("s_hi_y1", {5'd0, bus_hi.Y}, 8'h01);
      en  = 1'b1;
      req = 8'h80;
      tick();
      en = 1'b0;
      tick();
      check("s_hi_stall_y1", {5'd0, bus_hi.Y}, 8'h01);
      check("s_hi_stall_v", {7'd0, bus_hi.V}, 8'h01);
      check("s_hi_stall_pend", bus_hi.Pend, 8'h82);
      ack = 1'b1;
      tick();
      check("s_hi_y7", {5'd0, bus_hi.Y}, 8'h07);
      tick();
      ack = 1'b0;
      check("s_hi_v_idle", {7'd0, bus_hi.V}, 8'h00);
      check("s_hi_pend_empty", bus_hi.Pend, 8'h00);

      // Clear and same-cycle re-request: new request wins, re-presented via IDLE.
      en  = 1'b1;
      req = 8'h08;
      push_both(3'd3, 3'd3);
      push_both(3'd3, 3'd3);
      tick();
      en = 1'b0;
      tick();
      check("c_hi_y3", {5'd0, bus_hi.Y}, 8'h03);
      ack = 1'b1;
      en  = 1'b1;
      req = 8'h08;
      tick();
      en  = 1'b0;
      ack = 1'b0;
      check("c_hi_pend_kept", bus_hi.Pend, 8'h08);
      check("c_hi_v_bubble", {7'd0, bus_hi.V}, 8'h00);
      check("c_hi_no_drop", {7'd0, bus_hi.Drop}, 8'h00);
      tick();
      check("c_hi_re_v", {7'd0, bus_hi.V}, 8'h01);
      check("c_hi_re_y3", {5'd0, bus_hi.Y}, 8'h03);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("c_hi_drained", bus_hi.Pend, 8'h00);

      // Collision on an unpresented pending bit sets the sticky Drop.
      en  = 1'b1;
      req = 8'h08;
      tick();
      check("d_no_drop_yet", {7'd0, bus_hi.Drop}, 8'h00);
      tick();
      check("d_hi_drop_set", {7'd0, bus_hi.Drop}, 8'h01);
      check("d_lo_drop_set", {7'd0, bus_lo.Drop}, 8'h01);
      req = 8'h10;
      tick();
      en  = 1'b0;
      ack = 1'b1;
      push_both(3'd3, 3'd3);
      push_both(3'd4, 3'd4);
      tick();
      tick();
      ack = 1'b0;
      check("d_hi_v_idle", {7'd0, bus_hi.V}, 8'h00);
      check("d_hi_drop_sticky", {7'd0, bus_hi.Drop}, 8'h01);

      // Asynchronous reset between edges while a code is presented.
      en  = 1'b1;
      req = 8'hf0;
      tick();
      en = 1'b0;
      tick();
      check("r_hi_pend_f0", bus_hi.Pend, 8'hf0);
      check("r_hi_y7", {5'd0, bus_hi.Y}, 8'h07);
      check("r_lo_y4", {5'd0, bus_lo.Y}, 8'h04);
      #2;
      rst = 1'b1;
      #1;
      check("r_async_pend", bus_hi.Pend, 8'h00);
      check("r_async_v", {7'd0, bus_hi.V}, 8'h00);
      check("r_async_y", {5'd0, bus_hi.Y}, 8'h00);
      check("r_async_drop", {7'd0, bus_hi.Drop}, 8'h00);
      check("r_lo_async_v", {7'd0, bus_lo.V}, 8'h00);
      #1;
      rst = 1'b0;
      tick();
      tick();
      check("r_quiet_v", {7'd0, bus_hi.V}, 8'h00);
      ack = 1'b1;
      en  = 1'b1;
      req = 8'h01;
      push_both(3'd0, 3'd0);
      tick();
      en = 1'b0;
      tick();
      check("r_recover_v", {7'd0, bus_hi.V}, 8'h01);
      tick();
      ack = 1'b0;
      tick();

      check("hi_queue_drained", 8'(q_hi.size()), 8'h00);
      check("lo_queue_drained", 8'(q_lo.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/encode_8_3_seq.md
ENCODE_8_3_SEQ -- requirements
Module: encode_8_3_seq

Interface
REQ-001 The module SHALL have parameter PRIO_HIGH, default 1, meaning 1 = bit 7 highest priority and 0 = bit 0 highest priority.
REQ-002 The module SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port Rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The module SHALL have port En, input, 1 bit, request-capture enable.
REQ-005 The module SHALL have port I, input, 8 bits, request lines, one per index 0..7, sampled when En=1.
REQ-006 The module SHALL have port Ack, input, 1 bit, consumer accepts the presented code.
REQ-007 The module SHALL have port Y, output, 3 bits, the encoded index of the presented request.
REQ-008 The module SHALL have port V, output, 1 bit, Y is valid.
REQ-009 The module SHALL have port Pend, output, 8 bits, the pending-request register.
REQ-010 The module SHALL have port Drop, output, 1 bit, a sticky flag for a request that was lost to collision.

Function
REQ-011 Pend SHALL update each edge as (Pend & ~clr) | (En ? I : 8'h00); clr = one-hot of Y when V=1 and Ack=1, else 0.
REQ-012 On clearing a bit, a same-cycle new request on that index SHALL win: the bit stays set.
REQ-013 Drop SHALL set on any edge where En=1, I[k]=1, Pend[k]=1 and k is not cleared that cycle; Drop stays set until reset.
REQ-014 The block SHALL use an FSM with states IDLE (V=0) and HOLD (V=1).
REQ-015 In IDLE with Pend!=0, the next edge SHALL load Y with the highest-priority set bit of Pend (per PRIO_HIGH), set V=1 and enter HOLD.
REQ-016 In IDLE with Pend=0, the FSM SHALL remain in IDLE with V=0.
REQ-017 In HOLD with Ack=0, Y and V SHALL hold stable, even if higher-priority requests arrive.
REQ-018 In HOLD with Ack=1, let R = Pend & ~clr (current Pend, excluding same-cycle arrivals).
REQ-019 If R!=0, the next edge SHALL load Y with the highest-priority bit of R and stay in HOLD with V=1 (back-to-back, no bubble).
REQ-020 If R=0, the next edge SHALL return to IDLE with V=0; same-cycle arrivals are presented via IDLE one cycle later.
REQ-021 Latency: a request sampled at edge n with the FSM in IDLE and Pend=0 SHALL appear as V=1 with Y=index after edge n+1.
REQ-022 Ack while V=0 SHALL be ignored, with no clear and no state change.
REQ-023 En=0 SHALL block capture only; presentation and clearing continue.
REQ-024 Y SHALL be registered and glitch-free; Y is don't-care when V=0 but SHALL retain its last value.

Reset
REQ-025 On Rst=1, asynchronously: Pend=8'h00, Y=3'b000, V=0, Drop=0, FSM=IDLE.
REQ-026 Rst asserted mid-handshake SHALL discard all pending requests and the presented code.
REQ-027 The first capture after Rst deasserts SHALL occur on the first rising edge with Rst=0.

Verification
REQ-028 The bench SHALL cover: PRIO_HIGH=1; En=1, I=8'h24 for one cycle, Ack held 1 -> edge+1 V=1 Y=5; next edge Y=2; next edge V=0; Pend=8'h00; Drop=0.
REQ-029 The bench SHALL cover: PRIO_HIGH=0, same stimulus -> Y=2 then Y=5.
REQ-030 The bench SHALL cover: Y=1 presented with Ack=0; inject I=8'h80 -> Y stays 1 for the stall; after Ack, Y=7.
REQ-031 The bench SHALL cover: Pend=8'h08 (not yet presented); En=1, I=8'h08 -> Drop=1 and remains 1 through later traffic until Rst.
REQ-032 The bench SHALL cover: Y=3, V=1, Ack=1 with same-cycle I=8'h08 -> Pend[3] stays 1; Y=3 is re-presented after passing through IDLE (V=0 one cycle); Drop=0.
REQ-033 The bench SHALL cover: Rst pulsed between clock edges while V=1, Pend=8'hF0 -> outputs go immediately to Pend=0, V=0, Y=0, Drop=0; no V until new requests arrive.
